// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receiver FSM states and baud divisor helper
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  function automatic int baud_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversampling tick divider with synchronous phase restart
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(DIV + 1);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk)
    if (rst || restart) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable-frame UART receiver with majority-vote sampling and receive FIFO
module uart_rx_cfg import uart_pkg::*; #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overflow,
  output logic                          rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int EW  = DATA_BITS + 2;
  localparam int MID = OVERSAMPLE / 2;
  logic [1:0] sync;
  logic rx_s, tick, restart, mid, last, vote, commit, par_err;
  state_t state, next;
  logic [TW-1:0] tk;
  logic [BW-1:0] bc;
  logic [1:0] smp;
  logic [DATA_BITS-1:0] shr;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic pop, push, full;
  assign rx_s = sync[1];
  uart_baud_tick #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .restart(restart), .tick(tick));
  // smp holds the samples from ticks MID-1 and MID when the vote is taken at MID+1
  assign mid  = tick && tk == TW'(MID + 1);
  assign last = tick && tk == TW'(OVERSAMPLE - 1);
  assign vote = (smp[0] & smp[1]) | (rx_s & (smp[0] | smp[1]));
  always_ff @(posedge clk) begin
    sync  <= rst ? 2'b11 : {sync[0], rx};
    state <= rst ? IDLE : next;
  end
  always_comb begin
    next    = state;
    restart = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        restart = !rx_s;
        next    = rx_s ? IDLE : START;
      end
      START: next = (mid && vote) ? IDLE : last ? DATA : START;
      DATA: if (last && bc == BW'(DATA_BITS - 1))
        next = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
      uart_pkg::PARITY: next = last ? STOP : uart_pkg::PARITY;
      STOP: if (mid && (!vote || bc == BW'(STOP_BITS - 1))) begin
        commit = 1'b1;
        next   = rx_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: next = rx_s ? IDLE : WAIT_IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst || restart) begin
      tk      <= '0;
      bc      <= '0;
      par_err <= 1'b0;
    end else if (tick) begin
      tk  <= last ? '0 : tk + 1'b1;
      smp <= {smp[0], rx_s};
      if (last && (state == DATA || state == STOP))
        bc <= (state == DATA && bc == BW'(DATA_BITS - 1)) ? '0 : bc + 1'b1;
      if (mid && state == DATA) shr <= {vote, shr[DATA_BITS-1:1]};
      if (mid && state == uart_pkg::PARITY) par_err <= (^shr ^ vote) != (PARITY == PAR_ODD);
    end
  assign full        = count == CW'(FIFO_DEPTH);
  assign rx_valid    = count != '0;
  assign pop         = rx_valid && rx_ready;
  assign push        = commit && (!full || pop);
  assign rx_overflow = commit && full && !pop && !rst;
  always_ff @(posedge clk)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) mem[wp] <= {shr, !vote, par_err};
      wp    <= wp + AW'(push);
      rp    <= rp + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  assign {rx_data, rx_frame_err, rx_parity_err} = mem[rp];
  assign fifo_count = count;
  assign rx_busy    = state != IDLE;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for a no-parity and an even-parity receiver instance
module tb_uart_rx_cfg;
  localparam int BIT = 1600;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx [2];
  logic rdy [2];
  logic [7:0] dat [2];
  logic fe [2], pe [2], vld [2], ovf [2], busy [2];
  logic [2:0] cnt [2];
  logic [9:0] q0 [$];
  logic [9:0] q1 [$];
  logic [7:0] t1 [3] = '{8'h52, 8'h55, 8'h4E};
  int n_checks = 0;
  int n_fail = 0;
  int ovf_cnt = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD(10_000)) u_dut (
    .clk(clk), .rst(rst), .rx(rx[0]), .rx_data(dat[0]), .rx_frame_err(fe[0]),
    .rx_parity_err(pe[0]), .rx_valid(vld[0]), .rx_ready(rdy[0]), .rx_overflow(ovf[0]),
    .rx_busy(busy[0]), .fifo_count(cnt[0]));
  uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD(10_000), .PARITY(2)) u_par (
    .clk(clk), .rst(rst), .rx(rx[1]), .rx_data(dat[1]), .rx_frame_err(fe[1]),
    .rx_parity_err(pe[1]), .rx_valid(vld[1]), .rx_ready(rdy[1]), .rx_overflow(ovf[1]),
    .rx_busy(busy[1]), .fifo_count(cnt[1]));

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  task automatic monitor();
    logic [9:0] e;
    forever begin
      @(negedge clk);
      ovf_cnt += int'(ovf[0]) + int'(ovf[1]);
      if (vld[0] && rdy[0]) begin
        if (q0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop0: unexpected entry %h", {dat[0], fe[0], pe[0]});
        end else begin
          e = q0.pop_front();
          check("pop0", 32'({dat[0], fe[0], pe[0]}), 32'(e));
        end
      end
      if (vld[1] && rdy[1]) begin
        if (q1.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop1: unexpected entry %h", {dat[1], fe[1], pe[1]});
        end else begin
          e = q1.pop_front();
          check("pop1", 32'({dat[1], fe[1], pe[1]}), 32'(e));
        end
      end
    end
  endtask

  task automatic send(input int u, input logic [7:0] d, input logic use_par, input logic pbit, input logic stop_v);
    rx[u] = 1'b0;
    #BIT;
    for (int i = 0; i < 8; i++) begin
      rx[u] = d[i];
      #BIT;
    end
    if (use_par) begin
      rx[u] = pbit;
      #BIT;
    end
    rx[u] = stop_v;
    #BIT;
  endtask

  task automatic check_reset(input string name);
    for (int u = 0; u < 2; u++)
      check(name, 32'({dat[u], fe[u], pe[u], vld[u], ovf[u], busy[u], cnt[u]}), 32'(0));
  endtask

  initial begin
    rx[0] = 1'b1; rx[1] = 1'b1;
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset("reset_state");
    // clean frames
    foreach (t1[i]) begin
      q0.push_back({t1[i], 2'b00});
      send(0, t1[i], 1'b0, 1'b0, 1'b1);
      #(2 * BIT);
    end
    check("t1_drained", 32'(q0.size()), 32'(0));
    // short glitch is a false start
    rx[0] = 1'b0;
    #100 check("glitch_busy", 32'(busy[0]), 32'(1));
    #200 rx[0] = 1'b1;
    #BIT check("glitch_idle", 32'(busy[0]), 32'(0));
    check("glitch_count", 32'(cnt[0]), 32'(0));
    // bad stop bit followed by a held-low line
    q0.push_back({8'h52, 2'b10});
    send(0, 8'h52, 1'b0, 1'b0, 1'b0);
    #BIT check("wait_idle_busy", 32'(busy[0]), 32'(1));
    check("ferr_drained", 32'(q0.size()), 32'(0));
    rx[0] = 1'b1;
    #BIT check("wait_idle_exit", 32'(busy[0]), 32'(0));
    q0.push_back({8'h55, 2'b00});
    send(0, 8'h55, 1'b0, 1'b0, 1'b1);
    #(2 * BIT);
    // even parity instance
    q1.push_back({8'h52, 2'b00});
    send(1, 8'h52, 1'b1, 1'b1, 1'b1);
    #(2 * BIT);
    q1.push_back({8'h52, 2'b01});
    send(1, 8'h52, 1'b1, 1'b0, 1'b1);
    #(2 * BIT);
    q1.push_back({8'h0F, 2'b00});
    send(1, 8'h0F, 1'b1, 1'b0, 1'b1);
    #(2 * BIT);
    check("par_drained", 32'(q1.size()), 32'(0));
    // fill and overflow
    rdy[0] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) q0.push_back({8'(i), 2'b00});
      send(0, 8'(i), 1'b0, 1'b0, 1'b1);
      #BIT;
      if (i == 4) begin
        check("full_count", 32'(cnt[0]), 32'(4));
        check("no_ovf_yet", 32'(ovf_cnt), 32'(0));
      end
    end
    check("ovf_count", 32'(cnt[0]), 32'(4));
    check("ovf_pulses", 32'(ovf_cnt), 32'(1));
    check("ovf_head", 32'({vld[0], dat[0]}), 32'({1'b1, 8'h01}));
    rdy[0] = 1'b1;
    #100 check("drain_valid", 32'(vld[0]), 32'(0));
    check("drain_count", 32'(cnt[0]), 32'(0));
    check("drain_queue", 32'(q0.size()), 32'(0));
    // reset during data bit 3
    rx[0] = 1'b0;
    #BIT rx[0] = 1'b0;
    #BIT rx[0] = 1'b1;
    #BIT rx[0] = 1'b1;
    #BIT rx[0] = 1'b1;
    #(BIT / 2) rst = 1'b1;
    #20 rst = 1'b0;
    check_reset("midframe_reset");
    #(2 * BIT) check("post_reset_idle", 32'({busy[0], cnt[0]}), 32'(0));
    q0.push_back({8'h4E, 2'b00});
    send(0, 8'h4E, 1'b0, 1'b0, 1'b1);
    #(2 * BIT);
    check("final_q0", 32'(q0.size()), 32'(0));
    check("final_q1", 32'(q1.size()), 32'(0));
    check("final_ovf", 32'(ovf_cnt), 32'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
